// File: rtl/encrypter_stream.sv
// Transmit-side 7-bit stream encrypter: keyed bit-scramble on accept, ciphertext buffered in a small FIFO.
// Key loads are accepted only while the FIFO is empty, so every buffered word keeps the key it was encrypted with.
module encrypter_stream #(
   parameter int FIFO_DEPTH  = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic [6:0]             keyIn,
   input  logic                   keyLoad,
   output logic                   keyReady,
   output logic                   keyReject,
   input  logic [6:0]             plainIn,
   input  logic                   inValid,
   output logic                   inReady,
   output logic [6:0]             cipherOut,
   output logic                   cipherValid,
   input  logic                   cipherReady,
   output logic [COUNT_WIDTH-1:0] wordCount
);

   localparam int             PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);

   logic [6:0]       key;
   logic [6:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   occupancy;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic [6:0]       scrambled;
   logic [6:0]       cipherNext;

   // Even bits inverted, odd bits rotated right; the far-end decrypter undoes this with a left rotate.
   always_comb begin
      scrambled    = '0;
      scrambled[0] = ~plainIn[0];
      scrambled[2] = ~plainIn[2];
      scrambled[4] = ~plainIn[4];
      scrambled[6] = ~plainIn[6];
      scrambled[1] = plainIn[3];
      scrambled[3] = plainIn[5];
      scrambled[5] = plainIn[1];
      cipherNext   = scrambled ^ key;
   end

   assign empty       = (occupancy == '0);
   assign full        = (occupancy == FULL_LEVEL);
   assign keyReady    = empty;
   assign inReady     = !full && !keyLoad;
   assign cipherValid = !empty;
   assign cipherOut   = empty ? 7'h00 : mem[rdPtr];
   assign push        = inValid && inReady;
   assign pop         = cipherValid && cipherReady;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         key       <= '0;
         keyReject <= 1'b0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         wordCount <= '0;
      end else begin
         keyReject <= keyLoad && !keyReady;
         if (keyLoad && keyReady) begin
            key <= keyIn;
         end
         if (push) begin
            wrPtr     <= wrPtr + PTR_W'(1);
            wordCount <= wordCount + COUNT_WIDTH'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
            2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Storage needs no reset: cipherOut is masked by the occupancy count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wrPtr] <= cipherNext;
      end
   end

endmodule
